// File: rtl/keyboard_pkg.sv
// ============================================================================
// Module   : keyboard_pkg
// Purpose  : Shared scan-code constants, prefix FSM state type and the
//            scan-code to hex digit lookup tables for the hex-entry block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package keyboard_pkg;

  // Prefix and editing scan codes (PS/2 set 2)
  localparam logic [7:0] KC_BREAK = 8'hF0;
  localparam logic [7:0] KC_EXT   = 8'hE0;
  localparam logic [7:0] KC_BKSP  = 8'h66;
  localparam logic [7:0] KC_ESC   = 8'h76;
  localparam logic [7:0] KC_ENTER = 8'h5A;

  // Prefix tracking states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BREAK     = 2'd1,
    ST_EXT       = 2'd2,
    ST_EXT_BREAK = 2'd3
  } state_t;

  // Index in the table is the hex value produced: main-row 0..9, then A..F
  localparam logic [7:0] C_HEX_CODES [0:15] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
    8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B
  };

  // Numeric keypad 0..9
  localparam logic [7:0] C_KP_CODES [0:9] = '{
    8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C,
    8'h75, 8'h7D
  };

endpackage

`default_nettype wire

// File: rtl/keyboard_hex_lookup.sv
// ============================================================================
// Module   : keyboard_hex_lookup
// Purpose  : Combinational scan-code to hex digit decoder.
// Ports    : code      - scan-code byte
//            keypad_en - also accept numeric-keypad digit codes
//            is_digit  - code maps to a hex digit
//            digit     - decoded value (0 when is_digit is low)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keyboard_hex_lookup
  import keyboard_pkg::*;
(
  input  logic [7:0] code,
  input  logic       keypad_en,
  output logic       is_digit,
  output logic [3:0] digit
);

  always_comb begin
    is_digit = 1'b0;
    digit    = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (code == C_HEX_CODES[i]) begin
        is_digit = 1'b1;
        digit    = 4'(i);
      end
    end
    if (keypad_en) begin
      for (int i = 0; i < 10; i++) begin
        if (code == C_KP_CODES[i]) begin
          is_digit = 1'b1;
          digit    = 4'(i);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/keyboard_hex_entry.sv
// ============================================================================
// Module   : keyboard_hex_entry
// Purpose  : PS/2 scan-code hex entry accumulator with break/extended prefix
//            tracking, backspace, escape-clear and enter-commit.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            code, code_valid  - scan-code byte and its one-cycle strobe
//            entry, count, full- current entry (newest digit in [3:0]),
//                                digit count, entry full flag
//            result            - value captured at the last commit
//            result_valid      - one-cycle pulse when result updates
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keyboard_hex_entry
  import keyboard_pkg::*;
#(
  parameter int NDIGITS   = 4,
  parameter bit KEYPAD_EN = 1'b1,
  localparam int CW       = $clog2(NDIGITS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           code,
  input  logic                 code_valid,
  output logic [4*NDIGITS-1:0] entry,
  output logic [CW-1:0]        count,
  output logic                 full,
  output logic [4*NDIGITS-1:0] result,
  output logic                 result_valid
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_act_normal;
  logic                 w_act_ext;
  logic                 w_is_digit;
  logic [3:0]           w_digit;
  logic [4*NDIGITS-1:0] w_shifted;
  logic                 w_full;
  logic                 w_do_digit;
  logic                 w_do_bksp;
  logic                 w_do_esc;
  logic                 w_do_enter;

  logic [4*NDIGITS-1:0] r_entry;
  logic [CW-1:0]        r_count;
  logic [4*NDIGITS-1:0] r_result;
  logic                 r_result_valid;

  keyboard_hex_lookup u_lookup (
    .code      (code),
    .keypad_en (KEYPAD_EN),
    .is_digit  (w_is_digit),
    .digit     (w_digit)
  );

  // Prefix FSM state register; only moves on a strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else if (code_valid) begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus "this byte is a make code to act on" decode
  always_comb begin
    w_state_nxt  = r_state;
    w_act_normal = 1'b0;
    w_act_ext    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (code == KC_BREAK)    w_state_nxt = ST_BREAK;
        else if (code == KC_EXT) w_state_nxt = ST_EXT;
        else                     w_act_normal = code_valid;
      end
      ST_BREAK: begin
        // Repeated F0 keeps waiting for the released key's code
        if (code != KC_BREAK) w_state_nxt = ST_IDLE;
      end
      ST_EXT: begin
        if (code == KC_BREAK)     w_state_nxt = ST_EXT_BREAK;
        else if (code != KC_EXT) begin
          w_state_nxt = ST_IDLE;
          w_act_ext   = code_valid;
        end
      end
      ST_EXT_BREAK: w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  // New digit enters at the bottom; the oldest digit falls off the top
  generate
    if (NDIGITS == 1) begin : g_shift_single
      assign w_shifted = w_digit;
    end else begin : g_shift_multi
      assign w_shifted = {r_entry[4*NDIGITS-5:0], w_digit};
    end
  endgenerate

  assign w_full     = (r_count == CW'(NDIGITS));
  assign w_do_digit = w_act_normal && w_is_digit;
  assign w_do_bksp  = w_act_normal && (code == KC_BKSP);
  assign w_do_esc   = w_act_normal && (code == KC_ESC);
  // Only extended code honoured is keypad enter
  assign w_do_enter = (w_act_normal || w_act_ext) && (code == KC_ENTER);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_entry        <= '0;
      r_count        <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      if (w_do_enter) begin
        r_result       <= r_entry;
        r_result_valid <= 1'b1;
        r_entry        <= '0;
        r_count        <= '0;
      end else if (w_do_esc) begin
        r_entry <= '0;
        r_count <= '0;
      end else if (w_do_digit && !w_full) begin
        r_entry <= w_shifted;
        r_count <= r_count + CW'(1);
      end else if (w_do_bksp && (r_count != '0)) begin
        r_entry <= r_entry >> 4;
        r_count <= r_count - CW'(1);
      end
    end
  end

  assign entry        = r_entry;
  assign count        = r_count;
  assign full         = w_full;
  assign result       = r_result;
  assign result_valid = r_result_valid;

endmodule

`default_nettype wire

// File: tb/tb_keyboard_hex_entry.sv
// ============================================================================
// Module   : tb_keyboard_hex_entry
// Purpose  : Self-checking bench for keyboard_hex_entry; two instances
//            (keypad enabled / disabled) driven by the same byte stream and
//            compared against a digit-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keyboard_hex_entry;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  code = 8'h00;
  logic        code_valid = 1'b0;

  logic [15:0] e1, r1, e0, r0;
  logic [2:0]  c1, c0;
  logic        f1, f0, v1, v0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keyboard_hex_entry #(.NDIGITS(N), .KEYPAD_EN(1'b1)) dut_kp (
    .clk(clk), .rst(rst), .code(code), .code_valid(code_valid),
    .entry(e1), .count(c1), .full(f1), .result(r1), .result_valid(v1)
  );

  keyboard_hex_entry #(.NDIGITS(N), .KEYPAD_EN(1'b0)) dut_nk (
    .clk(clk), .rst(rst), .code(code), .code_valid(code_valid),
    .entry(e0), .count(c0), .full(f0), .result(r0), .result_valid(v0)
  );

  wire [36:0] obs [2];
  assign obs[0] = {e0, c0, f0, r0, v0};
  assign obs[1] = {e1, c1, f1, r1, v1};

  // ---------------- reference model ----------------
  // Entry kept as a list of typed digits, oldest first; index 1 = keypad on.
  logic [3:0]  md   [2][N];
  int          mcnt [2];
  logic [15:0] mres [2];
  bit          mrv  [2];
  bit          pend_break, pend_ext;

  function automatic int hexval(input logic [7:0] c, input bit kp);
    case (c)
      8'h45: return 0;  8'h16: return 1;  8'h1E: return 2;  8'h26: return 3;
      8'h25: return 4;  8'h2E: return 5;  8'h36: return 6;  8'h3D: return 7;
      8'h3E: return 8;  8'h46: return 9;  8'h1C: return 10; 8'h32: return 11;
      8'h21: return 12; 8'h23: return 13; 8'h24: return 14; 8'h2B: return 15;
      default: ;
    endcase
    if (kp) begin
      case (c)
        8'h70: return 0; 8'h69: return 1; 8'h72: return 2; 8'h7A: return 3;
        8'h6B: return 4; 8'h73: return 5; 8'h74: return 6; 8'h6C: return 7;
        8'h75: return 8; 8'h7D: return 9;
        default: ;
      endcase
    end
    return -1;
  endfunction

  function automatic logic [15:0] mentry(input int k);
    logic [15:0] v;
    v = 16'h0;
    for (int i = 0; i < mcnt[k]; i++) v = (v << 4) | 16'(md[k][i]);
    return v;
  endfunction

  function automatic logic [36:0] expv(input int k);
    return {mentry(k), 3'(mcnt[k]), (mcnt[k] == N), mres[k], mrv[k]};
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 0; mres[k] = 16'h0; mrv[k] = 1'b0;
    end
    pend_break = 1'b0; pend_ext = 1'b0;
  endtask

  task automatic m_enter();
    for (int k = 0; k < 2; k++) begin
      mres[k] = mentry(k); mrv[k] = 1'b1; mcnt[k] = 0;
    end
  endtask

  task automatic m_key(input logic [7:0] c);
    for (int k = 0; k < 2; k++) begin
      int d;
      d = hexval(c, k[0]);
      if (d >= 0) begin
        if (mcnt[k] < N) begin md[k][mcnt[k]] = 4'(d); mcnt[k]++; end
      end else if (c == 8'h66) begin
        if (mcnt[k] > 0) mcnt[k]--;
      end else if (c == 8'h76) begin
        mcnt[k] = 0;
      end
    end
    if (c == 8'h5A) m_enter();
  endtask

  task automatic m_byte(input logic [7:0] c);
    if (pend_break && pend_ext) begin
      pend_break = 0; pend_ext = 0;
    end else if (pend_break) begin
      if (c != 8'hF0) pend_break = 0;
    end else if (pend_ext) begin
      if (c == 8'hF0) pend_break = 1;
      else if (c != 8'hE0) begin
        pend_ext = 0;
        if (c == 8'h5A) m_enter();
      end
    end else begin
      if (c == 8'hF0)      pend_break = 1;
      else if (c == 8'hE0) pend_ext = 1;
      else                 m_key(c);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model.
  task automatic step(input bit v, input logic [7:0] c);
    @(negedge clk);
    code_valid = v; code = c;
    @(posedge clk);
    #1;
    mrv[0] = 0; mrv[1] = 0;
    if (v) m_byte(c);
  endtask

  task automatic pulse_reset(input bit v, input logic [7:0] c);
    @(negedge clk);
    rst = 1'b1; code_valid = v; code = c;
    @(posedge clk);
    #1;
    m_reset();
    @(negedge clk);
    rst = 1'b0; code_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    pulse_reset(1'b1, 8'h16);   // strobe during reset must be ignored
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== 37'h0) begin
        errors++; $display("FAIL reset kp%0d got %h want %h", k, obs[k], 37'h0);
      end
    end
  endtask

  task automatic run_seq(input string name, input logic [7:0] s[$]);
    foreach (s[i]) begin
      step(1'b1, s[i]);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== expv(k)) begin
          errors++;
          $display("FAIL %s[%0d] kp%0d got %h want %h", name, i, k, obs[k], expv(k));
        end
      end
    end
  endtask

  task automatic test_commit();
    run_seq("commit_keys", '{8'h1C, 8'h16, 8'h2B, 8'h45});
    checks++;
    if ({e1, c1, f1} !== {16'hA1F0, 3'd4, 1'b1}) begin
      errors++; $display("FAIL commit_entry got %h/%0d want a1f0/4", e1, c1);
    end
    run_seq("commit_enter", '{8'h5A});
    checks++;
    if ({r1, v1, e1, c1} !== {16'hA1F0, 1'b1, 16'h0, 3'd0}) begin
      errors++; $display("FAIL commit_result got %h v=%b want a1f0 v=1", r1, v1);
    end
    step(1'b0, 8'h5A);
    checks++;
    if (v1 !== 1'b0 || r1 !== 16'hA1F0) begin
      errors++; $display("FAIL commit_pulse got v=%b r=%h want v=0 r=a1f0", v1, r1);
    end
  endtask

  task automatic test_break();
    run_seq("break", '{8'h26, 8'hF0, 8'h26});
    checks++;
    if ({e1, c1} !== {16'h0003, 3'd1}) begin
      errors++; $display("FAIL break_entry got %h/%0d want 0003/1", e1, c1);
    end
    run_seq("break_clr", '{8'h76});
  endtask

  task automatic test_full_bksp();
    run_seq("full", '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E});
    checks++;
    if ({e1, f1} !== {16'h1234, 1'b1}) begin
      errors++; $display("FAIL full_entry got %h f=%b want 1234 f=1", e1, f1);
    end
    run_seq("bksp", '{8'h66});
    checks++;
    if ({e1, c1, f1} !== {16'h0123, 3'd3, 1'b0}) begin
      errors++; $display("FAIL bksp_entry got %h/%0d f=%b want 0123/3 f=0", e1, c1, f1);
    end
    run_seq("bksp_empty", '{8'h66, 8'h66, 8'h66, 8'h66, 8'h66});
  endtask

  task automatic test_keypad();
    run_seq("keypad", '{8'h69, 8'h69});
    checks++;
    if ({e1, e0, c0} !== {16'h0011, 16'h0, 3'd0}) begin
      errors++; $display("FAIL keypad got kp=%h nk=%h/%0d want 0011 0000/0", e1, e0, c0);
    end
    run_seq("keypad_ext", '{8'hE0, 8'h69, 8'hE0, 8'h70, 8'h76});
  endtask

  task automatic test_prefix_esc();
    run_seq("ext_enter", '{8'h16, 8'hE0, 8'h5A});
    checks++;
    if ({r1, v1} !== {16'h0001, 1'b1}) begin
      errors++; $display("FAIL ext_enter got %h v=%b want 0001 v=1", r1, v1);
    end
    run_seq("no_commit", '{8'h1E, 8'hE0, 8'hF0, 8'h5A, 8'hF0, 8'h5A, 8'hE0, 8'hE0, 8'hF0, 8'hF0});
    run_seq("esc", '{8'h26, 8'h25, 8'h76});
    checks++;
    if ({e1, c1, r1} !== {16'h0, 3'd0, 16'h0001}) begin
      errors++; $display("FAIL esc got %h/%0d r=%h want 0000/0 r=0001", e1, c1, r1);
    end
  endtask

  task automatic test_reset_mid();
    run_seq("mid_prefix", '{8'hF0});
    pulse_reset(1'b0, 8'h00);
    run_seq("mid_after", '{8'h16});
    checks++;
    if ({e1, c1} !== {16'h0001, 3'd1}) begin
      errors++; $display("FAIL reset_mid got %h/%0d want 0001/1", e1, c1);
    end
    run_seq("enter_empty", '{8'h76, 8'h5A});
    checks++;
    if ({r1, v1} !== {16'h0, 1'b1}) begin
      errors++; $display("FAIL enter_empty got %h v=%b want 0000 v=1", r1, v1);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pool [16] = '{8'hF0, 8'hE0, 8'h66, 8'h76, 8'h5A, 8'h16, 8'h2B,
                              8'h45, 8'h1C, 8'h69, 8'h7D, 8'h70, 8'h3E, 8'h24,
                              8'h00, 8'h66};
    for (int i = 0; i < 600; i++) begin
      bit v;
      logic [7:0] c;
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 7) == 0) ? 8'($urandom) : pool[$urandom_range(0, 15)];
      step(v, c);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== expv(k)) begin
          errors++;
          $display("FAIL random[%0d] kp%0d code=%h v=%b got %h want %h",
                   i, k, c, v, obs[k], expv(k));
        end
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_commit();
    test_break();
    test_full_bksp();
    test_keypad();
    test_prefix_esc();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
